ps2_key_decoder: RTL and testbench

- Receives the raw PS/2 keyboard clock/data lines and produces the 11-bit `ps2_key` event word that the core's keyboard logic consumes.
- It is the producing end of that interface: each completed keystroke toggles bit 10, carries press/release in bit 9, the E0 extended flag in bit 8 and the scan code in bits 7:0.
- It sits in the clk_sys domain beside the input mapping logic, for cores whose keyboard is not supplied by the HPS.

---
 rtl/ps2_key_decoder.sv | 220 ++++++++++++++++++++++
 tb/tb_ps2_key_decoder.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: conditions the raw clock/data lines, deframes 11-bit
// frames and turns scan-code bytes (with E0/F0/E1 prefixes) into ps2_key events.
module ps2_key_decoder #(
  parameter int FILT_CYC    = 8,
  parameter int TIMEOUT_CYC = 9600
) (
  input  logic        clk_sys,
  input  logic        RESET,
  input  logic        ps2_clk_in,
  input  logic        ps2_dat_in,
  output logic [10:0] ps2_key,
  output logic        frame_err,
  output logic        busy
);

  localparam int DATA_W = 8;
  localparam int FILT_W = $clog2(FILT_CYC + 1);
  localparam int TMO_W  = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  function automatic logic odd_parity_ok(input logic [DATA_W-1:0] data, input logic par);
    odd_parity_ok = (^data) ^ par;
  endfunction

  function automatic logic is_kbd_response(input logic [DATA_W-1:0] data);
    is_kbd_response = (data == 8'hFA) || (data == 8'hAA) || (data == 8'hEE) ||
                      (data == 8'hFE) || (data == 8'h00) || (data == 8'hFF);
  endfunction

  // Stage p0/p1: two-flop synchronisers, idle-high
  logic clk_p0, clk_p1, dat_p0, dat_p1;

  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      clk_p0 <= 1'b1;
      clk_p1 <= 1'b1;
      dat_p0 <= 1'b1;
      dat_p1 <= 1'b1;
    end else begin
      clk_p0 <= ps2_clk_in;
      clk_p1 <= clk_p0;
      dat_p0 <= ps2_dat_in;
      dat_p1 <= dat_p0;
    end
  end

  // Stage p2: level filters; a line only moves after FILT_CYC steady cycles
  logic              clk_filt_p2, dat_filt_p2, clk_filt_d;
  logic [FILT_W-1:0] clk_fcnt, dat_fcnt;

  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      clk_filt_p2 <= 1'b1;
      clk_fcnt    <= '0;
    end else if (clk_p1 != clk_filt_p2) begin
      if (clk_fcnt == FILT_W'(FILT_CYC - 1)) begin
        clk_filt_p2 <= clk_p1;
        clk_fcnt    <= '0;
      end else begin
        clk_fcnt <= clk_fcnt + FILT_W'(1);
      end
    end else begin
      clk_fcnt <= '0;
    end
  end

  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      dat_filt_p2 <= 1'b1;
      dat_fcnt    <= '0;
    end else if (dat_p1 != dat_filt_p2) begin
      if (dat_fcnt == FILT_W'(FILT_CYC - 1)) begin
        dat_filt_p2 <= dat_p1;
        dat_fcnt    <= '0;
      end else begin
        dat_fcnt <= dat_fcnt + FILT_W'(1);
      end
    end else begin
      dat_fcnt <= '0;
    end
  end

  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) clk_filt_d <= 1'b1;
    else       clk_filt_d <= clk_filt_p2;
  end

  logic fall_stb;
  assign fall_stb = clk_filt_d & ~clk_filt_p2;

  // Frame state machine and byte handling
  state_t            state, state_n;
  logic [2:0]        bit_cnt, bit_cnt_n;
  logic [TMO_W-1:0]  tmo_cnt, tmo_n;
  logic [DATA_W-1:0] shreg, shreg_n;
  logic              par_bit, par_n;
  logic              ext, ext_n, brk, brk_n;
  logic [2:0]        skip, skip_n;
  logic [10:0]       key_n;
  logic              err_n;
  logic              byte_vld;

  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      tmo_cnt   <= '0;
      ext       <= 1'b0;
      brk       <= 1'b0;
      skip      <= '0;
      ps2_key   <= '0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      tmo_cnt   <= tmo_n;
      ext       <= ext_n;
      brk       <= brk_n;
      skip      <= skip_n;
      ps2_key   <= key_n;
      frame_err <= err_n;
    end
  end

  always_ff @(posedge clk_sys) begin
    shreg   <= shreg_n;
    par_bit <= par_n;
  end

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    par_n     = par_bit;
    ext_n     = ext;
    brk_n     = brk;
    skip_n    = skip;
    key_n     = ps2_key;
    err_n     = 1'b0;
    byte_vld  = 1'b0;

    if (state == S_IDLE || fall_stb) tmo_n = '0;
    else                             tmo_n = tmo_cnt + TMO_W'(1);

    case (state)
      S_IDLE: begin
        if (fall_stb) begin
          if (!dat_filt_p2) begin
            state_n   = S_DATA;
            bit_cnt_n = '0;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      S_DATA: begin
        if (fall_stb) begin
          shreg_n   = {dat_filt_p2, shreg[DATA_W-1:1]};
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_n = S_PARITY;
        end
      end
      S_PARITY: begin
        if (fall_stb) begin
          par_n   = dat_filt_p2;
          state_n = S_STOP;
        end
      end
      S_STOP: begin
        if (fall_stb) begin
          state_n = S_IDLE;
          if (dat_filt_p2 && odd_parity_ok(shreg, par_bit)) begin
            byte_vld = 1'b1;
          end else begin
            err_n = 1'b1;
            ext_n = 1'b0;
            brk_n = 1'b0;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase

    // A strobe in the expiry cycle has already cleared the counter and wins
    if (state != S_IDLE && !fall_stb && tmo_cnt == TMO_W'(TIMEOUT_CYC - 1)) begin
      state_n = S_IDLE;
      tmo_n   = '0;
      err_n   = 1'b1;
      ext_n   = 1'b0;
      brk_n   = 1'b0;
    end

    if (byte_vld) begin
      if (skip != 3'd0) begin
        skip_n = skip - 3'd1;
      end else if (shreg == 8'hE1) begin
        skip_n = 3'd7;
      end else if (shreg == 8'hE0) begin
        ext_n = 1'b1;
      end else if (shreg == 8'hF0) begin
        brk_n = 1'b1;
      end else if (!ext && !brk && is_kbd_response(shreg)) begin
        key_n = ps2_key;
      end else begin
        key_n = {~ps2_key[10], ~brk, ext, shreg};
        ext_n = 1'b0;
        brk_n = 1'b0;
      end
    end
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: directed PS/2 frames plus a random
// byte stream compared against a byte-level model of the key event rules.
module tb_ps2_key_decoder;

  localparam int FILT_CYC    = 8;
  localparam int TIMEOUT_CYC = 9600;
  localparam int H           = 16;
  localparam int LAT         = 3 + FILT_CYC;

  logic        clk_sys = 1'b0;
  logic        RESET = 1'b0;
  logic        ps2_clk_in = 1'b1;
  logic        ps2_dat_in = 1'b1;
  logic [10:0] ps2_key;
  logic        frame_err;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int err_cnt = 0;
  bit err_prev = 1'b0;
  bit long_pulse = 1'b0;

  logic [10:0] exp_key;
  logic [10:0] m_key;
  bit          m_ext, m_brk;
  int          m_skip;

  ps2_key_decoder #(.FILT_CYC(FILT_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk_sys   (clk_sys),
    .RESET     (RESET),
    .ps2_clk_in(ps2_clk_in),
    .ps2_dat_in(ps2_dat_in),
    .ps2_key   (ps2_key),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk_sys = ~clk_sys;

  always @(negedge clk_sys) begin
    if (frame_err === 1'b1) err_cnt++;
    if (frame_err === 1'b1 && err_prev) long_pulse = 1'b1;
    err_prev = (frame_err === 1'b1);
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit bad_par);
    mk_frame = {1'b1, (~^b) ^ bad_par, b, 1'b0};
  endfunction

  // Drives the first nbits of a frame; lat = negedges after the last falling
  // clock until ps2_key changes or frame_err is seen (0 if neither).
  task automatic send_raw(input logic [10:0] bits, input int nbits, output int lat);
    logic [10:0] k0;
    k0  = ps2_key;
    lat = 0;
    for (int i = 0; i < nbits; i++) begin
      ps2_dat_in = bits[i];
      repeat (H) @(negedge clk_sys);
      ps2_clk_in = 1'b0;
      for (int c = 1; c <= H; c++) begin
        @(negedge clk_sys);
        if (i == nbits - 1 && lat == 0 && (ps2_key !== k0 || frame_err === 1'b1)) lat = c;
      end
      ps2_clk_in = 1'b1;
    end
    repeat (H) @(negedge clk_sys);
    ps2_dat_in = 1'b1;
    repeat (H) @(negedge clk_sys);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int lat;
    send_raw(mk_frame(b, 1'b0), 11, lat);
  endtask

  task automatic do_reset();
    @(negedge clk_sys);
    RESET = 1'b1;
    repeat (3) @(negedge clk_sys);
    RESET = 1'b0;
    repeat (2) @(negedge clk_sys);
    m_key = '0; m_ext = 0; m_brk = 0; m_skip = 0;
  endtask

  task automatic model_byte(input logic [7:0] b, input bit good);
    if (!good) begin
      m_ext = 0; m_brk = 0;
    end else if (m_skip > 0) begin
      m_skip--;
    end else if (b == 8'hE1) begin
      m_skip = 7;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else if (!m_ext && !m_brk && (b inside {8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF})) begin
      m_key = m_key;
    end else begin
      m_key = {~m_key[10], ~m_brk, m_ext, b};
      m_ext = 0; m_brk = 0;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (ps2_key !== 11'h000) begin errors++; $display("FAIL reset_key got %h want 000", ps2_key); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", frame_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    exp_key = 11'h000;
  endtask

  task automatic test_basic();
    int lat, e0;
    e0 = err_cnt;
    send_raw(mk_frame(8'h1C, 1'b0), 11, lat);
    exp_key = 11'h61C;
    checks++; if (ps2_key !== exp_key) begin errors++; $display("FAIL basic_key got %h want %h", ps2_key, exp_key); end
    checks++; if (lat != LAT) begin errors++; $display("FAIL basic_latency got %0d want %0d", lat, LAT); end
    checks++; if (err_cnt != e0) begin errors++; $display("FAIL basic_err got %0d pulses want 0", err_cnt - e0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy got %b want 0", busy); end
  endtask

  task automatic test_ext_release();
    send_byte(8'hE0);
    checks++; if (ps2_key !== exp_key) begin errors++; $display("FAIL ext_prefix_key got %h want %h", ps2_key, exp_key); end
    send_byte(8'hF0);
    checks++; if (ps2_key !== exp_key) begin errors++; $display("FAIL brk_prefix_key got %h want %h", ps2_key, exp_key); end
    send_byte(8'h75);
    exp_key = 11'h175;  // toggle 1->0, released, extended
    checks++; if (ps2_key !== exp_key) begin errors++; $display("FAIL ext_release_key got %h want %h", ps2_key, exp_key); end
  endtask

  task automatic test_parity_err();
    int lat, e0;
    e0 = err_cnt;
    send_raw(mk_frame(8'h29, 1'b1), 11, lat);
    checks++; if (err_cnt - e0 != 1) begin errors++; $display("FAIL parity_err_pulses got %0d want 1", err_cnt - e0); end
    checks++; if (lat != LAT) begin errors++; $display("FAIL parity_err_latency got %0d want %0d", lat, LAT); end
    checks++; if (ps2_key !== exp_key) begin errors++; $display("FAIL parity_err_key got %h want %h", ps2_key, exp_key); end
    send_byte(8'h29);
    exp_key = 11'h629;
    checks++; if (ps2_key !== exp_key) begin errors++; $display("FAIL parity_recover_key got %h want %h", ps2_key, exp_key); end
  endtask

  task automatic test_timeout();
    int lat, e0, waited;
    bit seen;
    e0 = err_cnt;
    send_raw(mk_frame(8'h16, 1'b0), 5, lat);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL timeout_busy_partial got %b want 1", busy); end
    seen = 0; waited = 0;
    while (!seen && waited < TIMEOUT_CYC + 2000) begin
      @(negedge clk_sys);
      waited++;
      if (frame_err === 1'b1) seen = 1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL timeout_pulse got none within %0d cycles want 1", waited); end
    @(negedge clk_sys);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout_busy_after got %b want 0", busy); end
    checks++; if (err_cnt - e0 != 1) begin errors++; $display("FAIL timeout_pulses got %0d want 1", err_cnt - e0); end
    checks++; if (waited < TIMEOUT_CYC - 4 * H || waited > TIMEOUT_CYC) begin
      errors++; $display("FAIL timeout_delay got %0d cycles want %0d..%0d", waited, TIMEOUT_CYC - 4 * H, TIMEOUT_CYC);
    end
    send_byte(8'h16);
    exp_key = 11'h216;
    checks++; if (ps2_key !== exp_key) begin errors++; $display("FAIL timeout_recover_key got %h want %h", ps2_key, exp_key); end
  endtask

  task automatic test_glitch();
    int e0;
    e0 = err_cnt;
    ps2_clk_in = 1'b0;
    repeat (3) @(negedge clk_sys);
    ps2_clk_in = 1'b1;
    repeat (3 * H) @(negedge clk_sys);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy got %b want 0", busy); end
    checks++; if (err_cnt != e0) begin errors++; $display("FAIL glitch_err got %0d pulses want 0", err_cnt - e0); end
    checks++; if (ps2_key !== exp_key) begin errors++; $display("FAIL glitch_key got %h want %h", ps2_key, exp_key); end
    do_reset();
    exp_key = 11'h000;
    send_byte(8'hAA);
    checks++; if (ps2_key !== exp_key) begin errors++; $display("FAIL response_aa_key got %h want %h", ps2_key, exp_key); end
  endtask

  task automatic test_pause();
    logic [7:0] seq [8];
    seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    for (int i = 0; i < 8; i++) begin
      send_byte(seq[i]);
      checks++; if (ps2_key !== exp_key) begin errors++; $display("FAIL pause_byte%0d_key got %h want %h", i, ps2_key, exp_key); end
    end
    send_byte(8'h1E);
    exp_key = 11'h61E;
    checks++; if (ps2_key !== exp_key) begin errors++; $display("FAIL pause_after_key got %h want %h", ps2_key, exp_key); end
  endtask

  task automatic test_reset_mid();
    int lat;
    send_byte(8'hE0);
    send_raw(mk_frame(8'h5A, 1'b0), 5, lat);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midreset_busy_before got %b want 1", busy); end
    RESET = 1'b1;
    #1;
    checks++; if (ps2_key !== 11'h000 || busy !== 1'b0 || frame_err !== 1'b0) begin
      errors++; $display("FAIL midreset_outputs got key=%h busy=%b err=%b want 000/0/0", ps2_key, busy, frame_err);
    end
    repeat (3) @(negedge clk_sys);
    RESET = 1'b0;
    repeat (2) @(negedge clk_sys);
    send_byte(8'h1E);
    exp_key = 11'h61E;
    checks++; if (ps2_key !== exp_key) begin errors++; $display("FAIL midreset_recover_key got %h want %h", ps2_key, exp_key); end
  endtask

  task automatic test_random();
    logic [7:0] b;
    bit bad;
    int r, lat, e0;
    do_reset();
    for (int n = 0; n < 36; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 12)      b = 8'hE0;
      else if (r < 26) b = 8'hF0;
      else if (r < 29) b = 8'hE1;
      else if (r < 38) begin
        case ($urandom_range(0, 5))
          0: b = 8'hFA; 1: b = 8'hAA; 2: b = 8'hEE;
          3: b = 8'hFE; 4: b = 8'h00; default: b = 8'hFF;
        endcase
      end else b = 8'($urandom_range(1, 8'h83));
      bad = ($urandom_range(0, 9) == 0);
      e0 = err_cnt;
      send_raw(mk_frame(b, bad), 11, lat);
      model_byte(b, !bad);
      checks++; if (ps2_key !== m_key) begin errors++; $display("FAIL rand%0d_key byte=%h got %h want %h", n, b, ps2_key, m_key); end
      checks++; if (err_cnt - e0 != (bad ? 1 : 0)) begin
        errors++; $display("FAIL rand%0d_err got %0d pulses want %0d", n, err_cnt - e0, bad ? 1 : 0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ext_release();
    test_parity_err();
    test_timeout();
    test_glitch();
    test_pause();
    test_reset_mid();
    test_random();
    checks++; if (long_pulse) begin errors++; $display("FAIL err_pulse_width got >1 cycle want 1"); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
